// File: rtl/vreg_pkg.sv
// Shared definitions for the vector register file: default geometry,
// the widths derived from it, and the bulk-clear state encoding.
package vreg_pkg;

    // Default geometry.
    localparam int NREGS_DEF = 16;  // number of vector registers
    localparam int NELEM_DEF = 16;  // elements per vector
    localparam int EW_DEF    = 16;  // element width in bits

    // Widths derived from the defaults.
    localparam int AW_DEF = $clog2(NREGS_DEF);  // register address
    localparam int IW_DEF = $clog2(NELEM_DEF);  // element index
    localparam int LW_DEF = IW_DEF + 1;         // length, 0..NELEM
    localparam int VW_DEF = NELEM_DEF * EW_DEF; // whole vector

    // Bulk-clear controller states.
    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_t;

endpackage : vreg_pkg

// File: rtl/vreg_mask_merge.sv
// Per-element merge of an old and a new vector under a write mask.
// Element i of the result comes from new_data where mask[i]=1, otherwise
// from old_data. Used both to build the stored value and the forwarded
// read value, so the two can never disagree.
//
// Ports:
//   old_data  in  VW     current register contents
//   new_data  in  VW     incoming write data
//   mask      in  NELEM  per-element write enable
//   merged    out VW     merged vector
module vreg_mask_merge
    import vreg_pkg::*;
#(
    parameter  int NELEM = NELEM_DEF,
    parameter  int EW    = EW_DEF,
    localparam int VW    = NELEM * EW
) (
    input  logic [VW-1:0]    old_data,
    input  logic [VW-1:0]    new_data,
    input  logic [NELEM-1:0] mask,
    output logic [VW-1:0]    merged
);

    always_comb begin
        // NOTE: the output gets a full default before any conditional
        // override, so every path assigns it and no latch is inferred.
        merged = old_data;
        for (int i = 0; i < NELEM; i++) begin
            if (mask[i]) begin
                merged[i*EW +: EW] = new_data[i*EW +: EW];
            end
        end
    end

endmodule : vreg_mask_merge

// File: rtl/vreg_file_p.sv
// Vector register file: NREGS vectors of NELEM elements, each with a
// stored length. Two combinational full-vector read ports (optionally
// forwarding a same-cycle write), one combinational single-element read
// port, one masked write port, and a bulk clear that sweeps one register
// per cycle while holding off writes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rAddr0/1  in  AW    full-vector read addresses
//   rData0/1  out VW    read data, element i at [i*EW +: EW]
//   r_len0/1  out LW    stored length of the addressed register
//   eAddr     in  AW    element read register
//   eIdx      in  IW    element read index
//   eData     out EW    element read data (never forwarded)
//   wEn       in  1     write request
//   wAddr     in  AW    write register
//   wLen      in  LW    write length (saturated to NELEM)
//   wData     in  VW    write data
//   wMask     in  NELEM per-element write mask
//   w_ready   out 1     write accepted when wEn & w_ready
//   clr_req   in  1     start bulk clear
//   clr_busy  out 1     sweep in progress
//   clr_done  out 1     one-cycle pulse when the sweep finishes
module vreg_file_p
    import vreg_pkg::*;
#(
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NELEM  = NELEM_DEF,
    parameter  int EW     = EW_DEF,
    parameter  int BYPASS = 0,
    localparam int AW     = $clog2(NREGS),
    localparam int IW     = $clog2(NELEM),
    localparam int LW     = IW + 1,
    localparam int VW     = NELEM * EW
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [AW-1:0]    rAddr0,
    input  logic [AW-1:0]    rAddr1,
    output logic [VW-1:0]    rData0,
    output logic [VW-1:0]    rData1,
    output logic [LW-1:0]    r_len0,
    output logic [LW-1:0]    r_len1,

    input  logic [AW-1:0]    eAddr,
    input  logic [IW-1:0]    eIdx,
    output logic [EW-1:0]    eData,

    input  logic             wEn,
    input  logic [AW-1:0]    wAddr,
    input  logic [LW-1:0]    wLen,
    input  logic [VW-1:0]    wData,
    input  logic [NELEM-1:0] wMask,
    output logic             w_ready,

    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    clr_state_t    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          done_q, done_d;

    logic [VW-1:0] data_q [NREGS];
    logic [LW-1:0] len_q  [NREGS];

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic          w_acc;
    logic [LW-1:0] wlen_sat;
    logic [VW-1:0] w_merged;
    logic [VW-1:0] e_vec;

    // Writes are only taken while no sweep is running.
    assign w_ready  = (state_q == CLR_IDLE);
    assign w_acc    = wEn & w_ready;
    assign wlen_sat = (wLen > LW'(NELEM)) ? LW'(NELEM) : wLen;

    vreg_mask_merge #(
        .NELEM (NELEM),
        .EW    (EW)
    ) u_merge (
        .old_data (data_q[wAddr]),
        .new_data (wData),
        .mask     (wMask),
        .merged   (w_merged)
    );

    // ------------------------------------------------------------------
    // Clear controller: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        unique case (state_q)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_d = CLR_SWEEP;
                    ptr_d   = '0;
                end
            end
            CLR_SWEEP: begin
                // clr_req is deliberately not looked at here.
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == AW'(NREGS - 1)) begin
                    state_d = CLR_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Clear controller: registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // clr_done is registered so it lands on the first cycle back in IDLE.
    assign clr_busy = (state_q == CLR_SWEEP);
    assign clr_done = done_q;

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    // NOTE: contents must read as zero the moment rst_n falls, so the
    // array is built from asynchronously reset flops rather than a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                data_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else if (state_q == CLR_SWEEP) begin
            data_q[ptr_q] <= '0;
            len_q[ptr_q]  <= '0;
        end else if (w_acc) begin
            data_q[wAddr] <= w_merged;
            len_q[wAddr]  <= wlen_sat;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    // A forwarded read of wAddr sees exactly the value that will be
    // stored, since the merge output is shared with the write path.
    always_comb begin
        rData0 = data_q[rAddr0];
        r_len0 = len_q[rAddr0];
        rData1 = data_q[rAddr1];
        r_len1 = len_q[rAddr1];
        if (BYPASS != 0 && w_acc) begin
            if (wAddr == rAddr0) begin
                rData0 = w_merged;
                r_len0 = wlen_sat;
            end
            if (wAddr == rAddr1) begin
                rData1 = w_merged;
                r_len1 = wlen_sat;
            end
        end
    end

    // The element port always reflects stored contents only.
    assign e_vec = data_q[eAddr];
    assign eData = e_vec[eIdx*EW +: EW];

endmodule : vreg_file_p

// File: tb/tb_vreg_file_p.sv
// Directed bench for vreg_file_p. Two instances share all inputs: dut0
// without forwarding, dut1 with forwarding. Expected values come from a
// behavioural model and are pushed to a scoreboard queue before each
// sample, then popped and compared against the DUT outputs.
module tb_vreg_file_p;

    localparam int NREGS = 16;
    localparam int NELEM = 16;
    localparam int EW    = 16;
    localparam int AW    = 4;
    localparam int IW    = 4;
    localparam int LW    = 5;
    localparam int VW    = NELEM * EW;

    logic             clk;
    logic             rst_n;
    logic [AW-1:0]    rAddr0, rAddr1, eAddr, wAddr;
    logic [IW-1:0]    eIdx;
    logic             wEn, clr_req;
    logic [LW-1:0]    wLen;
    logic [VW-1:0]    wData;
    logic [NELEM-1:0] wMask;

    logic [VW-1:0] d0_rData0, d0_rData1, d1_rData0, d1_rData1;
    logic [LW-1:0] d0_r_len0, d0_r_len1, d1_r_len0, d1_r_len1;
    logic [EW-1:0] d0_eData, d1_eData;
    logic          d0_w_ready, d0_clr_busy, d0_clr_done;
    logic          d1_w_ready, d1_clr_busy, d1_clr_done;

    vreg_file_p #(.NREGS(NREGS), .NELEM(NELEM), .EW(EW), .BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .rAddr0(rAddr0), .rAddr1(rAddr1),
        .rData0(d0_rData0), .rData1(d0_rData1),
        .r_len0(d0_r_len0), .r_len1(d0_r_len1),
        .eAddr(eAddr), .eIdx(eIdx), .eData(d0_eData),
        .wEn(wEn), .wAddr(wAddr), .wLen(wLen), .wData(wData), .wMask(wMask),
        .w_ready(d0_w_ready),
        .clr_req(clr_req), .clr_busy(d0_clr_busy), .clr_done(d0_clr_done)
    );

    vreg_file_p #(.NREGS(NREGS), .NELEM(NELEM), .EW(EW), .BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .rAddr0(rAddr0), .rAddr1(rAddr1),
        .rData0(d1_rData0), .rData1(d1_rData1),
        .r_len0(d1_r_len0), .r_len1(d1_r_len1),
        .eAddr(eAddr), .eIdx(eIdx), .eData(d1_eData),
        .wEn(wEn), .wAddr(wAddr), .wLen(wLen), .wData(wData), .wMask(wMask),
        .w_ready(d1_w_ready),
        .clr_req(clr_req), .clr_busy(d1_clr_busy), .clr_done(d1_clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        string         tag;
        logic [VW-1:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    logic [VW-1:0] mdl_data [NREGS];
    logic [LW-1:0] mdl_len  [NREGS];

    task automatic push(input string tag, input logic [VW-1:0] e);
        sb_t it;
        it.tag = tag;
        it.exp = e;
        sb_q.push_back(it);
    endtask

    task automatic check(input logic [VW-1:0] obs);
        sb_t it;
        n_assert++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h with nothing expected", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        push(tag, VW'(exp));
        check(VW'(obs));
    endtask

    function automatic logic [VW-1:0] mmerge(input logic [VW-1:0] o,
                                             input logic [VW-1:0] n,
                                             input logic [NELEM-1:0] m);
        logic [VW-1:0] r;
        r = o;
        for (int i = 0; i < NELEM; i++)
            if (m[i]) r[i*EW +: EW] = n[i*EW +: EW];
        return r;
    endfunction

    function automatic logic [LW-1:0] msat(input logic [LW-1:0] l);
        return (int'(l) > NELEM) ? LW'(NELEM) : l;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [VW-1:0] fill_vec(input logic [EW-1:0] e);
        logic [VW-1:0] v;
        for (int i = 0; i < NELEM; i++) v[i*EW +: EW] = e;
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) begin
            mdl_data[i] = '0;
            mdl_len[i]  = '0;
        end
    endtask

    // Accepted write in IDLE; model updated after the edge.
    task automatic do_write(input int a, input logic [VW-1:0] d,
                            input logic [NELEM-1:0] m, input logic [LW-1:0] l);
        @(negedge clk);
        wEn = 1'b1; wAddr = AW'(a); wData = d; wMask = m; wLen = l;
        @(posedge clk);
        #1;
        wEn = 1'b0;
        mdl_data[a] = mmerge(mdl_data[a], d, m);
        mdl_len[a]  = msat(l);
    endtask

    // Read register a on port 0, its mirror on port 1, and element a.
    task automatic chk_reg(input int a, input string tag);
        int b;
        b = NREGS - 1 - a;
        @(negedge clk);
        rAddr0 = AW'(a); rAddr1 = AW'(b); eAddr = AW'(a); eIdx = IW'(a);
        push($sformatf("%s_r%0d_d0_data0", tag, a), mdl_data[a]);
        push($sformatf("%s_r%0d_d0_data1", tag, b), mdl_data[b]);
        push($sformatf("%s_r%0d_d0_len0", tag, a), VW'(mdl_len[a]));
        push($sformatf("%s_r%0d_d0_len1", tag, b), VW'(mdl_len[b]));
        push($sformatf("%s_r%0d_d0_edata", tag, a), VW'(mdl_data[a][a*EW +: EW]));
        push($sformatf("%s_r%0d_d1_data0", tag, a), mdl_data[a]);
        push($sformatf("%s_r%0d_d1_len0", tag, a), VW'(mdl_len[a]));
        #1;
        check(d0_rData0);
        check(d0_rData1);
        check(VW'(d0_r_len0));
        check(VW'(d0_r_len1));
        check(VW'(d0_eData));
        check(d1_rData0);
        check(VW'(d1_r_len0));
    endtask

    task automatic scan(input string tag);
        for (int a = 0; a < NREGS; a++) chk_reg(a, tag);
    endtask

    task automatic fill_all();
        for (int a = 0; a < NREGS; a++) do_write(a, rand_vec(), '1, LW'(a + 1));
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        logic [VW-1:0] v, v_old, v_new;
        int            busy0, busy1, done0, done1, done_at;
        logic          seen;

        rst_n = 1'b0; wEn = 1'b0; clr_req = 1'b0;
        rAddr0 = '0; rAddr1 = '0; eAddr = '0; eIdx = '0;
        wAddr = '0; wLen = '0; wData = '0; wMask = '0;
        model_clear();
        #23 rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        chk_bit("rst_w_ready_d0", d0_w_ready, 1'b1);
        chk_bit("rst_w_ready_d1", d1_w_ready, 1'b1);
        chk_bit("rst_busy_d0", d0_clr_busy, 1'b0);
        chk_bit("rst_done_d0", d0_clr_done, 1'b0);
        scan("reset");

        // Full write of reg3 with elements 0..15.
        for (int i = 0; i < NELEM; i++) v[i*EW +: EW] = EW'(i);
        do_write(3, v, 16'hFFFF, 5'd16);
        chk_reg(3, "wr_full");
        @(negedge clk);
        eAddr = 4'd3; eIdx = 4'd5;
        push("edata_r3_e5", VW'(16'h0005));
        #1 check(VW'(d0_eData));

        // Masked write: only elements 4..7 change, length 8.
        do_write(3, fill_vec(16'hAAAA), 16'h00F0, 5'd8);
        chk_reg(3, "wr_mask");
        @(negedge clk);
        eAddr = 4'd3; eIdx = 4'd4;
        push("edata_r3_e4", VW'(16'hAAAA));
        #1 check(VW'(d0_eData));
        eIdx = 4'd8;
        push("edata_r3_e8", VW'(16'h0008));
        #1 check(VW'(d0_eData));
        push("len_r3_masked", VW'(5'd8));
        rAddr0 = 4'd3;
        #1 check(VW'(d0_r_len0));

        // Zero mask: length only.
        do_write(3, fill_vec(16'h5555), 16'h0000, 5'd2);
        chk_reg(3, "wr_lenonly");

        // Same-cycle write/read on reg7: dut0 old, dut1 forwarded.
        do_write(7, rand_vec(), 16'hFFFF, 5'd16);
        v_new = rand_vec();
        @(negedge clk);
        wEn = 1'b1; wAddr = 4'd7; wData = v_new; wMask = 16'h0F0F; wLen = 5'd20;
        rAddr0 = 4'd7; rAddr1 = 4'd7; eAddr = 4'd7; eIdx = 4'd0;
        v_old = mdl_data[7];
        push("byp_d0_data0_old", v_old);
        push("byp_d0_len0_old", VW'(mdl_len[7]));
        push("byp_d1_data0_new", mmerge(v_old, v_new, 16'h0F0F));
        push("byp_d1_data1_new", mmerge(v_old, v_new, 16'h0F0F));
        push("byp_d1_len0_sat", VW'(5'd16));
        push("byp_d1_len1_sat", VW'(5'd16));
        push("byp_d1_edata_old", VW'(v_old[EW-1:0]));
        #1;
        check(d0_rData0);
        check(VW'(d0_r_len0));
        check(d1_rData0);
        check(d1_rData1);
        check(VW'(d1_r_len0));
        check(VW'(d1_r_len1));
        check(VW'(d1_eData));
        @(posedge clk);
        #1 wEn = 1'b0;
        mdl_data[7] = mmerge(v_old, v_new, 16'h0F0F);
        mdl_len[7]  = msat(5'd20);
        chk_reg(7, "byp_after");

        // Length saturation.
        do_write(9, rand_vec(), 16'hFFFF, 5'd31);
        chk_reg(9, "sat31");
        do_write(9, rand_vec(), 16'h8001, 5'd17);
        chk_reg(9, "sat17");

        // Bulk clear with writes attempted during the sweep.
        fill_all();
        scan("filled");
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk);
        #1 clr_req = 1'b0;
        busy0 = 0; busy1 = 0; done0 = 0; done1 = 0; done_at = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            wEn = (cyc < 16); wAddr = 4'd15; wData = fill_vec(16'hDEAD);
            wMask = '1; wLen = 5'd3; rAddr0 = 4'd15;
            #1;
            if (cyc == 0) begin
                push("sweep_w_ready_d0", VW'(1'b0));
                push("sweep_w_ready_d1", VW'(1'b0));
                push("sweep_read_d0", mdl_data[15]);
                push("sweep_nobyp_d1", mdl_data[15]);
                check(VW'(d0_w_ready));
                check(VW'(d1_w_ready));
                check(d0_rData0);
                check(d1_rData0);
            end
            busy0 += int'(d0_clr_busy);
            busy1 += int'(d1_clr_busy);
            if (d0_clr_done) begin
                done0++;
                if (done_at < 0) done_at = cyc;
            end
            done1 += int'(d1_clr_done);
        end
        wEn = 1'b0;
        push("busy_cycles_d0", VW'(16));
        check(VW'(busy0));
        push("busy_cycles_d1", VW'(16));
        check(VW'(busy1));
        push("done_pulses_d0", VW'(1));
        check(VW'(done0));
        push("done_pulses_d1", VW'(1));
        check(VW'(done1));
        push("done_cycle_d0", VW'(16));
        check(VW'(done_at));
        model_clear();
        scan("cleared");

        // Reset during sweep cycle 5.
        fill_all();
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk);
        #1 clr_req = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rAddr0 = 4'd10; rAddr1 = 4'd2;
        rst_n = 1'b0;
        #1;
        push("abort_d0_data0_zero", '0);
        push("abort_d0_len0_zero", '0);
        push("abort_d1_data1_zero", '0);
        check(d0_rData0);
        check(VW'(d0_r_len0));
        check(d1_rData1);
        chk_bit("abort_busy_d0", d0_clr_busy, 1'b0);
        chk_bit("abort_done_d0", d0_clr_done, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            seen |= d0_clr_done | d1_clr_done | d0_clr_busy | d1_clr_busy;
        end
        chk_bit("abort_no_done_no_busy", seen, 1'b0);
        chk_bit("abort_w_ready_d0", d0_w_ready, 1'b1);
        model_clear();
        scan("abort");

        // Write and clear request in the same IDLE cycle.
        v = rand_vec();
        @(negedge clk);
        clr_req = 1'b1; wEn = 1'b1; wAddr = 4'd4; wData = v; wMask = '1; wLen = 5'd6;
        @(posedge clk);
        #1 begin clr_req = 1'b0; wEn = 1'b0; end
        mdl_data[4] = v;
        mdl_len[4]  = 5'd6;
        @(negedge clk);
        rAddr0 = 4'd4;
        #1;
        push("clrwr_written_d0", mdl_data[4]);
        push("clrwr_len_d0", VW'(mdl_len[4]));
        check(d0_rData0);
        check(VW'(d0_r_len0));
        chk_bit("clrwr_busy_d0", d0_clr_busy, 1'b1);
        seen = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge clk);
            seen = d0_clr_done;
        end
        chk_bit("clrwr_done_within_bound", seen, 1'b1);
        model_clear();
        chk_reg(4, "clrwr_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_vreg_file_p
